// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: pointer width helper and Gray/binary
// conversions used by both the read-side and write-side pointer blocks.
package async_fifo_pkg;

  // Default memory address width; pointers carry one extra wrap bit.
  localparam int unsigned ADDR_WIDTH_DFLT = 4;

  // Width of the conversion helpers. Narrower pointers are zero-extended
  // on the way in and truncated on the way out. Leading zeros do not change
  // the low-order Gray/binary bits, so truncating the result is exact.
  localparam int unsigned GRAY_FN_W = 32;
  typedef logic [GRAY_FN_W-1:0] gray_word_t;

  // Pointer width for a given memory address width.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  localparam int unsigned PTR_WIDTH_DFLT = ptr_width(ADDR_WIDTH_DFLT);

  // Binary to reflected Gray code.
  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB down, in log2(width) steps.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int unsigned s = 1; s < GRAY_FN_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// The stages are a plain shift chain with no logic between them. The same
// block carries rd_ptr_gray into the write domain.
module ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("ptr_sync: SYNC_STAGES must be in 2..4");
  end

  // Stage 0 captures the asynchronous input; the last stage is the output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift chain with synchronous clear of every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/read_pointer_ctrl.sv
// Read-side pointer and empty-flag controller for the async FIFO.
// Runs entirely in the read clock domain: synchronises the Gray write pointer,
// advances the read pointer on accepted reads, and registers empty, occupancy
// and a sticky underflow flag.
// Optional feature macro: RD_ALMOST_EMPTY_EN adds a registered almost_empty.
module read_pointer_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = ADDR_WIDTH_DFLT,
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  read_valid,
`ifdef RD_ALMOST_EMPTY_EN
  output logic                  almost_empty,
`endif
  output logic                  underflow
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  if (ALMOST_EMPTY_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_thresh
    $error("read_pointer_ctrl: ALMOST_EMPTY_THRESH exceeds FIFO depth");
  end

  // Write pointer as seen in the read domain, SYNC_STAGES edges late.
  logic [PTR_W-1:0] wq;
  logic [PTR_W-1:0] wq_bin;

  ptr_sync #(
    .WIDTH       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (wr_ptr_gray),
    .q_o   (wq)
  );

  // Registered state and its next-state values.
  logic [PTR_W-1:0] rd_bin_q,   rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q,  rd_gray_d;
  logic [PTR_W-1:0] count_q,    count_d;
  logic             empty_q,    empty_d;
  logic             valid_q,    valid_d;
  logic             underflow_q, underflow_d;
  logic             rd_fire;

  // Next-state computation. Empty, count and the pointer all derive from the
  // same post-read pointer, so a read coinciding with a freshly synchronised
  // write pointer is resolved consistently and the last read drops straight
  // into empty with no bubble.
  always_comb begin
    rd_fire     = read_en & ~empty_q;
    rd_bin_d    = rd_bin_q + PTR_W'(rd_fire);
    rd_gray_d   = PTR_W'(bin2gray(gray_word_t'(rd_bin_d)));
    wq_bin      = PTR_W'(gray2bin(gray_word_t'(wq)));
    // Full-width compare including the wrap bit: equal pointers mean empty.
    empty_d     = (rd_gray_d == wq);
    count_d     = wq_bin - rd_bin_d;
    valid_d     = rd_fire;
    underflow_d = underflow_q | (read_en & empty_q);
  end

  // Pointer, flag and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  logic almost_empty_q, almost_empty_d;

  // Almost-empty tracks the same next-state occupancy as rd_count.
  always_comb begin
    almost_empty_d = (count_d <= PTR_W'(ALMOST_EMPTY_THRESH));
  end

  // Almost-empty register; an emptied FIFO is trivially almost empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_empty = almost_empty_q;
`endif

  assign rd_ptr_gray = rd_gray_q;
  assign rd_addr     = rd_bin_q[ADDR_WIDTH-1:0];
  assign empty       = empty_q;
  assign rd_count    = count_q;
  assign read_valid  = valid_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_read_pointer_ctrl.sv
// Directed bench for read_pointer_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2).
// The almost_empty section is built only when RD_ALMOST_EMPTY_EN is defined.
module tb_read_pointer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_en;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic [3:0] rd_addr;
  logic       empty;
  logic [4:0] rd_count;
  logic       read_valid;
  logic       underflow;
`ifdef RD_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int n_vec = 0;
  int n_err = 0;

  read_pointer_ctrl #(
    .ADDR_WIDTH          (4),
    .SYNC_STAGES         (2),
    .ALMOST_EMPTY_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_en      (read_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_ptr_gray  (rd_ptr_gray),
    .rd_addr      (rd_addr),
    .empty        (empty),
    .rd_count     (rd_count),
    .read_valid   (read_valid),
`ifdef RD_ALMOST_EMPTY_EN
    .almost_empty (almost_empty),
`endif
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset read side and model the write side as reset too (pointer 0).
  task automatic do_reset();
    reset       = 1'b1;
    read_en     = 1'b0;
    wr_ptr_gray = 5'd0;
    ticks(2);
    reset = 1'b0;
  endtask

  function automatic logic [4:0] g(input int w);
    logic [4:0] b;
    b = 5'(w);
    return b ^ (b >> 1);
  endfunction

  initial begin
    int pulses;
    reset       = 1'b1;
    read_en     = 1'b0;
    wr_ptr_gray = 5'b00101;

    // 1: reset with a nonzero write pointer at the input.
    tick();
    check_eq("rst_empty0", 32'(empty), 32'd1);
    check_eq("rst_cnt0",   32'(rd_count), 32'd0);
    tick();
    check_eq("rst_empty1", 32'(empty), 32'd1);
    check_eq("rst_gray1",  32'(rd_ptr_gray), 32'd0);
    check_eq("rst_uf1",    32'(underflow), 32'd0);
    check_eq("rst_valid1", 32'(read_valid), 32'd0);
    check_eq("rst_addr1",  32'(rd_addr), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("rel_empty", 32'(empty), 32'd1);
    check_eq("rel_cnt",   32'(rd_count), 32'd0);
    check_eq("rel_gray",  32'(rd_ptr_gray), 32'd0);
    check_eq("rel_uf",    32'(underflow), 32'd0);
    do_reset();

    // 2: one word; empty falls exactly 3 edges later, single read.
    wr_ptr_gray = 5'b00001;
    tick();
    check_eq("lat_e1", 32'(empty), 32'd1);
    tick();
    check_eq("lat_e2", 32'(empty), 32'd1);
    tick();
    check_eq("lat_e3", 32'(empty), 32'd0);
    check_eq("lat_cnt", 32'(rd_count), 32'd1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check_eq("rd1_valid", 32'(read_valid), 32'd1);
    check_eq("rd1_addr",  32'(rd_addr), 32'd1);
    check_eq("rd1_gray",  32'(rd_ptr_gray), 32'd1);
    check_eq("rd1_empty", 32'(empty), 32'd1);
    check_eq("rd1_cnt",   32'(rd_count), 32'd0);
    tick();
    check_eq("rd1_valid_off", 32'(read_valid), 32'd0);
    check_eq("rd1_uf", 32'(underflow), 32'd0);

    // 3: full FIFO (bin 16 = gray 11000), burst of 20 read requests.
    do_reset();
    wr_ptr_gray = 5'b11000;
    ticks(3);
    check_eq("full_empty", 32'(empty), 32'd0);
    check_eq("full_cnt",   32'(rd_count), 32'd16);
    read_en = 1'b1;
    pulses  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (read_valid) pulses++;
      check_eq("burst_cnt",   32'(rd_count), (k < 16) ? 32'(16 - k) : 32'd0);
      check_eq("burst_empty", 32'(empty), 32'(k >= 16));
      check_eq("burst_uf",    32'(underflow), 32'(k >= 17));
    end
    read_en = 1'b0;
    check_eq("burst_pulses", 32'(pulses), 32'd16);
    ticks(3);
    check_eq("uf_sticky", 32'(underflow), 32'd1);
    check_eq("burst_addr", 32'(rd_addr), 32'd0);
    check_eq("burst_gray", 32'(rd_ptr_gray), 32'b11000);

    // 4: step write pointer through 1..31 and back to 0, reading in lockstep.
    do_reset();
    for (int w = 1; w <= 32; w++) begin
      wr_ptr_gray = g(w % 32);
      ticks(3);
      check_eq("wrap_pre_empty", 32'(empty), 32'd0);
      check_eq("wrap_pre_cnt",   32'(rd_count), 32'd1);
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check_eq("wrap_addr",  32'(rd_addr), 32'(w % 16));
      check_eq("wrap_gray",  32'(rd_ptr_gray), 32'(g(w % 32)));
      check_eq("wrap_empty", 32'(empty), 32'd1);
      check_eq("wrap_cnt",   32'(rd_count), 32'd0);
      if (w == 31) check_eq("wrap_g31", 32'(rd_ptr_gray), 32'b10000);
      if (w == 32) check_eq("wrap_g0",  32'(rd_ptr_gray), 32'b00000);
    end
    check_eq("wrap_uf", 32'(underflow), 32'd0);

    // 5: reset with 5 words held, then 2 words with read_en held high.
    do_reset();
    wr_ptr_gray = 5'b00111;
    ticks(3);
    check_eq("mid_cnt5", 32'(rd_count), 32'd5);
    reset       = 1'b1;
    wr_ptr_gray = 5'd0;
    tick();
    reset = 1'b0;
    check_eq("mid_empty", 32'(empty), 32'd1);
    check_eq("mid_cnt",   32'(rd_count), 32'd0);
    check_eq("mid_valid", 32'(read_valid), 32'd0);
    check_eq("mid_uf",    32'(underflow), 32'd0);
    check_eq("mid_addr",  32'(rd_addr), 32'd0);
    check_eq("mid_gray",  32'(rd_ptr_gray), 32'd0);
    wr_ptr_gray = 5'b00011;
    read_en     = 1'b1;
    tick();
    check_eq("rs1_empty", 32'(empty), 32'd1);
    check_eq("rs1_valid", 32'(read_valid), 32'd0);
    check_eq("rs1_uf",    32'(underflow), 32'd1);
    tick();
    check_eq("rs2_empty", 32'(empty), 32'd1);
    check_eq("rs2_valid", 32'(read_valid), 32'd0);
    tick();
    check_eq("rs3_empty", 32'(empty), 32'd0);
    check_eq("rs3_cnt",   32'(rd_count), 32'd2);
    check_eq("rs3_valid", 32'(read_valid), 32'd0);
    tick();
    check_eq("rs4_valid", 32'(read_valid), 32'd1);
    check_eq("rs4_cnt",   32'(rd_count), 32'd1);
    check_eq("rs4_empty", 32'(empty), 32'd0);
    check_eq("rs4_addr",  32'(rd_addr), 32'd1);
    tick();
    check_eq("rs5_valid", 32'(read_valid), 32'd1);
    check_eq("rs5_empty", 32'(empty), 32'd1);
    check_eq("rs5_cnt",   32'(rd_count), 32'd0);
    check_eq("rs5_addr",  32'(rd_addr), 32'd2);
    read_en = 1'b0;
    tick();
    check_eq("rs6_valid", 32'(read_valid), 32'd0);

`ifdef RD_ALMOST_EMPTY_EN
    // 6: four words (gray 00110), read one at a time, threshold 2.
    do_reset();
    check_eq("ae_rst", 32'(almost_empty), 32'd1);
    wr_ptr_gray = 5'b00110;
    ticks(3);
    check_eq("ae_cnt4", 32'(rd_count), 32'd4);
    check_eq("ae_at4",  32'(almost_empty), 32'd0);
    read_en = 1'b1; tick(); read_en = 1'b0;
    check_eq("ae_cnt3", 32'(rd_count), 32'd3);
    check_eq("ae_at3",  32'(almost_empty), 32'd0);
    read_en = 1'b1; tick(); read_en = 1'b0;
    check_eq("ae_cnt2", 32'(rd_count), 32'd2);
    check_eq("ae_at2",  32'(almost_empty), 32'd1);
    read_en = 1'b1; tick(); read_en = 1'b0;
    check_eq("ae_cnt1", 32'(rd_count), 32'd1);
    check_eq("ae_at1",  32'(almost_empty), 32'd1);
    read_en = 1'b1; tick(); read_en = 1'b0;
    check_eq("ae_cnt0", 32'(rd_count), 32'd0);
    check_eq("ae_at0",  32'(almost_empty), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/read_pointer_ctrl.md
Name: read_pointer_ctrl

Overview:
Read-side pointer and empty-flag controller for the async FIFO. It is the counterpart of the write-side pointer block.
- Runs entirely in the read clock domain.
- Synchronises the write pointer (Gray) into this domain through a flop chain.
- Advances a binary/Gray read pointer on accepted reads.
- Generates registered empty, occupancy count and a sticky underflow flag.
- Drives the memory read address, and returns the Gray read pointer to the write side for its full check.

Parameters:
- ADDR_WIDTH, 4, memory address width; pointers are ADDR_WIDTH+1 bits (5 by default, depth 16).
- SYNC_STAGES, 2, flop stages synchronising wr_ptr_gray; legal values 2..4.
- ALMOST_EMPTY_THRESH, 2, occupancy at or below which almost_empty asserts (feature builds only).

Ports:
- clk  in  1  read-domain clock.
- reset  in  1  synchronous, active-high reset.
- read_en  in  1  read request from the consumer.
- wr_ptr_gray  in  ADDR_WIDTH+1  Gray write pointer from the write domain (asynchronous to clk).
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
- rd_addr  out  ADDR_WIDTH  low bits of the binary read pointer, to the memory read port.
- empty  out  1  registered; FIFO holds no data visible to the reader.
- rd_count  out  ADDR_WIDTH+1  registered occupancy seen by the reader.
- read_valid  out  1  registered; a read was accepted on the previous edge.
- underflow  out  1  sticky; read_en was seen while empty.

Behaviour:
Reset (synchronous, active-high):
- Synchronous, active-high: all state clears on the first clk edge with reset=1.
- Clears rd_bin, rd_ptr_gray and all synchroniser stages to 0.
- Outputs after reset: empty=1, rd_count=0, read_valid=0, underflow=0, rd_addr=0.
- Mid-operation reset discards pending synchroniser contents; the bench must also reset the write side.

Synchroniser:
- wq = wr_ptr_gray delayed SYNC_STAGES clk edges.
- No logic is allowed between stages.

Read acceptance:
- rd_fire = read_en & ~empty.
- On rd_fire: rd_bin_next = rd_bin + 1, wrapping modulo 2^(ADDR_WIDTH+1) (31 -> 0 by default).
- rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
- rd_ptr_gray and rd_addr update on the same edge. rd_addr is the pointer of the next word to read.
- read_valid <= rd_fire.

Empty:
- empty <= (rd_gray_next == wq).
- The read-side comparison uses all bits, including the MSB; this differs from the write-side full test.
- Empty deasserts no earlier than SYNC_STAGES+1 clk edges after wr_ptr_gray changes.
- On the read of the last word, empty asserts on that same edge; there is no extra bubble.

Occupancy:
- rd_count <= gray2bin(wq) - rd_bin_next, modulo 2^(ADDR_WIDTH+1).
- Always 0..2^ADDR_WIDTH. It is conservative, because the synchronised write pointer lags the real one.

Underflow:
- read_en=1 with empty=1 does not move the pointer.
- It sets underflow, which stays at 1 until reset.

Simultaneous events:
- A read and a newly arrived write pointer are handled on the same edge from the same next-state values, so there are no races.
- read_en held high across empty->nonempty: a read is accepted on the first cycle empty=0.

wr_ptr_gray input:
- Must change by at most one bit per write clock.
- Never checked inside this block.

Optional Feature:
RD_ALMOST_EMPTY_EN.
- Defined: adds a registered almost_empty output. almost_empty <= (next rd_count <= ALMOST_EMPTY_THRESH); its reset value is 1.
- Undefined: the port and its logic are absent; ALMOST_EMPTY_THRESH is unused.

Decomposition:
- Shared package async_fifo_pkg holds:
  - the pointer-width constant (ADDR_WIDTH+1);
  - the gray2bin and bin2gray functions, also used by the write-side pointer block.
- One natural sub-module, ptr_sync: a parameterised multi-flop synchroniser (WIDTH, SYNC_STAGES, synchronous reset).
- The same ptr_sync is reused on the write side for rd_ptr_gray.

Test Plan:
1. Reset: hold reset=1 for 2 edges with wr_ptr_gray=5'b00101 -> empty=1, rd_count=0, rd_ptr_gray=0, underflow=0 throughout reset and on the first edge after release.
2. Latency: after reset, change wr_ptr_gray 0 -> 5'b00001 (1 word) -> empty falls exactly 3 edges later (SYNC_STAGES=2), rd_count=1; read_en for 1 cycle -> read_valid=1, rd_addr=1, rd_ptr_gray=5'b00001, empty=1 on the same edge.
3. Burst: set wr_ptr_gray=bin2gray(16) (FIFO full), wait 3 edges, hold read_en=1 for 20 cycles -> exactly 16 read_valid pulses, rd_count 16->0, empty=1 after the 16th read, then underflow=1 and stays at 1.
4. Wrap: drive the write pointer in steps to 31 then 0, reading in lockstep -> rd_ptr_gray goes 5'b10000 -> 5'b00000, rd_addr 15 -> 0, empty and rd_count stay consistent, no spurious underflow.
5. Reset mid-operation: with rd_count=5, assert reset for 1 edge -> all outputs return to reset values; the next read is accepted only after the write pointer is re-synchronised.
6. RD_ALMOST_EMPTY_EN defined, THRESH=2: fill to 4 words and read one at a time -> almost_empty=0 at counts 4 and 3, and 1 at counts 2, 1 and 0.
